booth_seq_ctrl: RTL and testbench

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

---
 rtl/booth_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_ctrl
// Description : Sequential radix-4 Booth multiplier, 8x8 signed -> 16-bit.
//               Operands are captured and Booth-encoded at start. One digit
//               is accumulated per cycle. Zero digits can optionally be
//               skipped so that they cost no cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] y,
  output logic [2:0]  digits_used
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      a_reg;
  logic [3:0][2:0] digs;        // signed Booth digit values, -2..+2
  logic [3:0]      pending;     // digits still to be visited
  logic [15:0]     acc;
  logic [2:0]      cnt;

  logic [8:0]      b_ext;
  logic [3:0][2:0] enc_digs;
  logic [3:0]      enc_zero;
  logic [3:0]      init_mask;
  logic            accept;
  logic [1:0]      cur_idx;
  logic [3:0]      pending_nxt;
  logic            last;
  logic [15:0]     a_shift;
  logic [15:0]     term;
  logic [15:0]     acc_sum;

  // Map a Booth triple (b[2i+1], b[2i], b[2i-1]) to its digit value.
  function automatic logic [2:0] booth_enc(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: booth_enc = 3'b001;  // +1
      3'b011:         booth_enc = 3'b010;  // +2
      3'b100:         booth_enc = 3'b110;  // -2
      3'b101, 3'b110: booth_enc = 3'b111;  // -1
      default:        booth_enc = 3'b000;  // 000 / 111
    endcase
  endfunction

  // Encode the incoming multiplier; digits that will be visited form the mask.
  always_comb begin
    b_ext    = {b, 1'b0};
    enc_digs = '0;
    enc_zero = '0;
    for (int i = 0; i < 4; i++) begin
      enc_digs[i] = booth_enc(b_ext[2*i+2 -: 3]);
      enc_zero[i] = (b_ext[2*i+2 -: 3] == 3'b000) || (b_ext[2*i+2 -: 3] == 3'b111);
    end
    init_mask = SKIP_ZERO ? ~enc_zero : 4'hF;
  end

  // Pick the lowest pending digit and form its partial product.
  always_comb begin
    cur_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) cur_idx = 2'(i);
    end
    pending_nxt = pending & ~(4'b0001 << cur_idx);
    last        = (pending_nxt == 4'b0000);
    a_shift     = {{8{a_reg[7]}}, a_reg} << {cur_idx, 1'b0};
    case (digs[cur_idx])
      3'b001:  term = a_shift;
      3'b010:  term = a_shift << 1;
      3'b110:  term = -(a_shift << 1);
      3'b111:  term = -a_shift;
      default: term = 16'h0000;
    endcase
    acc_sum = acc + term;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs; start is honoured outside CALC only.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ready     = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = (init_mask == 4'b0000) ? DONE : CALC;
      end
      CALC: begin
        busy  = 1'b1;
        ready = 1'b0;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (start) state_nxt = (init_mask == 4'b0000) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= '0;
      digs        <= '0;
      pending     <= '0;
      acc         <= '0;
      cnt         <= '0;
      y           <= '0;
      digits_used <= '0;
    end else if (accept) begin
      a_reg   <= a;
      digs    <= enc_digs;
      pending <= init_mask;
      acc     <= '0;
      cnt     <= '0;
      // Nothing to visit: the result is final right away.
      if (init_mask == 4'b0000) begin
        y           <= '0;
        digits_used <= '0;
      end
    end else if (state == CALC) begin
      acc     <= acc_sum;
      pending <= pending_nxt;
      cnt     <= cnt + 3'd1;
      if (last) begin
        y           <= acc_sum;
        digits_used <= cnt + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_ctrl
// Description : Directed bench for booth_seq_ctrl with both SKIP_ZERO values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ready0, busy0, done0, ready1, busy1, done1;
  logic [15:0] y0, y1;
  logic [2:0]  du0, du1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] y;
    logic [2:0]  du;
    int          lat;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  booth_seq_ctrl #(.SKIP_ZERO(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
    .ready(ready0), .busy(busy0), .done(done0), .y(y0), .digits_used(du0)
  );

  booth_seq_ctrl #(.SKIP_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .y(y1), .digits_used(du1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Number of non-zero radix-4 digits in the multiplier.
  function automatic int count_nz(input logic [7:0] bv);
    logic [8:0] ext;
    int n;
    ext = {bv, 1'b0};
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (ext[2*i+2 -: 3] != 3'b000 && ext[2*i+2 -: 3] != 3'b111) n++;
    end
    return n;
  endfunction

  task automatic push_exp(input bit sel, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    logic [15:0] sa, sbv;
    sa  = {{8{av[7]}}, av};
    sbv = {{8{bv[7]}}, bv};
    e.y = sa * sbv;
    if (sel) begin
      e.du  = 3'd4;
      e.lat = 5;
      sb1.push_back(e);
    end else begin
      e.du  = 3'(count_nz(bv));
      e.lat = count_nz(bv) + 1;
      sb0.push_back(e);
    end
  endtask

  // Present an operation and let it be accepted on the next rising edge.
  task automatic start_op(input bit sel, input logic [7:0] av, input logic [7:0] bv, input bit keep);
    if (sel) begin start1 = 1'b1; a1 = av; b1 = bv; end
    else     begin start0 = 1'b1; a0 = av; b0 = bv; end
    push_exp(sel, av, bv);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (sel) start1 = 1'b0;
      else     start0 = 1'b0;
    end
  endtask

  // Wait for done after an accept; returns at the negedge of the done cycle.
  task automatic wait_done(input bit sel, input string tag);
    bit   seen;
    int   lat;
    exp_t e;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ((sel ? done1 : done0) === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      chk({tag, ".busy"},  32'(sel ? busy1 : busy0), 32'd1);
      chk({tag, ".ready"}, 32'(sel ? ready1 : ready0), 32'd0);
    end
    if (sel) e = sb1.pop_front();
    else     e = sb0.pop_front();
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
      chk({tag, ".y"},  32'(sel ? y1 : y0), 32'(e.y));
      chk({tag, ".du"}, 32'(sel ? du1 : du0), 32'(e.du));
    end
  endtask

  initial begin
    logic [7:0] corners [4];
    logic [7:0] ra, rb;
    corners[0] = 8'h00; corners[1] = 8'h7F; corners[2] = 8'h80; corners[3] = 8'hFF;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset state
    #1;
    chk("rst.ready", 32'(ready0), 32'd1);
    chk("rst.busy",  32'(busy0),  32'd0);
    chk("rst.done",  32'(done0),  32'd0);
    chk("rst.y",     32'(y0),     32'd0);
    chk("rst.du",    32'(du0),    32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First start straight after reset; 5*3
    start_op(0, 8'h05, 8'h03, 0);
    wait_done(0, "op05x03");
    @(negedge clk);
    chk("done_one_cycle", 32'(done0), 32'd0);

    start_op(0, 8'h80, 8'h80, 0);
    wait_done(0, "op80x80");

    start_op(0, 8'h7F, 8'hFF, 0);
    wait_done(0, "op7Fxff");
    repeat (2) @(negedge clk);
    chk("y_hold", 32'(y0), 32'hFF81);
    chk("du_hold", 32'(du0), 32'd1);

    start_op(0, 8'h12, 8'h00, 0);
    wait_done(0, "op12x00");

    // start held in CALC with other operands, then back-to-back from DONE
    @(negedge clk);
    start_op(0, 8'h05, 8'h03, 1);
    a0 = 8'h11; b0 = 8'h22;
    wait_done(0, "b2b_first");
    a0 = 8'h03; b0 = 8'h07;
    push_exp(0, 8'h03, 8'h07);
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done(0, "b2b_second");

    // Reset in the middle of CALC
    @(negedge clk);
    start_op(0, 8'h05, 8'h03, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.y",     32'(y0),     32'd0);
    chk("midrst.busy",  32'(busy0),  32'd0);
    chk("midrst.ready", 32'(ready0), 32'd1);
    chk("midrst.du",    32'(du0),    32'd0);
    void'(sb0.pop_front());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst.no_done", 32'(done0), 32'd0);
    end
    start_op(0, 8'h05, 8'h03, 0);
    wait_done(0, "post_rst");

    // A few random operands on the skipping instance
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      start_op(0, ra, rb, 0);
      wait_done(0, "rand_skip");
    end

    // Non-skipping instance: corners then random operands
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        start_op(1, corners[i], corners[j], 0);
        wait_done(1, "corner_noskip");
      end
    end
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      start_op(1, ra, rb, 0);
      wait_done(1, "rand_noskip");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
